// File: rtl/retire_writeback.sv
// ----------------------------------------------------------------------------
// retire_writeback
//
// Final pipeline stage. It takes completed results from the accessor over a
// valid/ready handshake, buffers them in a two-entry in-order queue, and
// writes them to the regfile write port. S0 is the head and S1 is the skid
// entry. The block also:
//   - answers rs1/rs2 bypass lookups from the decoder,
//   - numbers every retiring instruction,
//   - raises the sticky core trap once a trapping result drains.
//
// Handshake rule (accessor -> this block):
//   A beat transfers on every posedge where accessor_valid & writeback_ready.
//   writeback_ready is derived from registered state only and never looks at
//   accessor_valid. The accessor holds its beat until the beat is taken.
//   The write port has no handshake back. The head drains on any cycle where
//   wport_ready is high.
//
// Ports:
//   clk, reset                 clock and asynchronous active-low reset
//   accessor_valid/_rd/_rd_data/_trap, writeback_ready   result input
//   wport_ready, wen, waddr, wdata                        regfile write port
//   fwd_rs1/2 -> fwd_hit1/2, fwd_data1/2                  decoder bypass
//   retire_valid, retire_order                            retirement stream
//   trap                                                  sticky core trap
//   fsm_state                                             debug view of FSM
// ----------------------------------------------------------------------------
module retire_writeback #(
  parameter int ORDER_W = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               accessor_valid,
  output logic               writeback_ready,
  input  logic [4:0]         accessor_rd,
  input  logic [31:0]        accessor_rd_data,
  input  logic               accessor_trap,
  input  logic               wport_ready,
  output logic               wen,
  output logic [4:0]         waddr,
  output logic [31:0]        wdata,
  input  logic [4:0]         fwd_rs1,
  input  logic [4:0]         fwd_rs2,
  output logic               fwd_hit1,
  output logic               fwd_hit2,
  output logic [31:0]        fwd_data1,
  output logic [31:0]        fwd_data2,
  output logic               retire_valid,
  output logic [ORDER_W-1:0] retire_order,
  output logic               trap,
  output logic [0:0]         fsm_state
);

  localparam logic [0:0] ST_RUN     = 1'b0;
  localparam logic [0:0] ST_TRAPPED = 1'b1;

  logic [0:0]         state_q;
  // run_en_q holds writeback_ready low until the first edge after reset
  // is released.
  logic               run_en_q;
  logic               s0_valid_q, s0_trap_q;
  logic [4:0]         s0_rd_q;
  logic [31:0]        s0_data_q;
  logic               s1_valid_q, s1_trap_q;
  logic [4:0]         s1_rd_q;
  logic [31:0]        s1_data_q;
  logic [ORDER_W-1:0] order_q;

  logic running;
  logic accept;
  logic drain;
  logic drain_trap;

  assign running         = (state_q == ST_RUN);
  assign writeback_ready = run_en_q & running & ~s1_valid_q;
  assign accept          = accessor_valid & writeback_ready;
  assign drain           = running & s0_valid_q & wport_ready;
  assign drain_trap      = drain & s0_trap_q;

  assign wen          = drain & ~s0_trap_q & (s0_rd_q != 5'd0);
  assign waddr        = s0_valid_q ? s0_rd_q : 5'd0;
  assign wdata        = s0_valid_q ? s0_data_q : 32'd0;
  assign retire_valid = drain;
  assign retire_order = order_q;
  assign trap         = (state_q == ST_TRAPPED);
  assign fsm_state    = state_q;

  // Bypass lookup. S1 holds the younger result, so it takes priority over S0.
  // Trapping entries never forward, and neither does register x0.
  function automatic logic [32:0] lookup(input logic [4:0] rs);
    logic [32:0] r;
    r = 33'd0;
    if (running && rs != 5'd0) begin
      if (s1_valid_q && !s1_trap_q && s1_rd_q == rs)
        r = {1'b1, s1_data_q};
      else if (s0_valid_q && !s0_trap_q && s0_rd_q == rs)
        r = {1'b1, s0_data_q};
    end
    return r;
  endfunction

  always_comb begin
    fwd_hit1  = 1'b0;
    fwd_data1 = 32'd0;
    fwd_hit2  = 1'b0;
    fwd_data2 = 32'd0;
    {fwd_hit1, fwd_data1} = lookup(fwd_rs1);
    {fwd_hit2, fwd_data2} = lookup(fwd_rs2);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_RUN;
      run_en_q   <= 1'b0;
      s0_valid_q <= 1'b0;
      s0_trap_q  <= 1'b0;
      s0_rd_q    <= 5'd0;
      s0_data_q  <= 32'd0;
      s1_valid_q <= 1'b0;
      s1_trap_q  <= 1'b0;
      s1_rd_q    <= 5'd0;
      s1_data_q  <= 32'd0;
      order_q    <= '0;
    end else begin
      run_en_q <= 1'b1;
      if (drain)
        order_q <= order_q + ORDER_W'(1);

      if (drain_trap) begin
        // Everything younger than the trapping beat is dropped, including a
        // beat accepted in this same cycle.
        state_q    <= ST_TRAPPED;
        s0_valid_q <= 1'b0;
        s1_valid_q <= 1'b0;
      end else if (drain) begin
        if (s1_valid_q) begin
          // While S1 is full, writeback_ready is low, so no beat can be
          // accepted in this branch.
          s0_valid_q <= 1'b1;
          s0_trap_q  <= s1_trap_q;
          s0_rd_q    <= s1_rd_q;
          s0_data_q  <= s1_data_q;
          s1_valid_q <= 1'b0;
        end else begin
          s0_valid_q <= accept;
          if (accept) begin
            s0_trap_q <= accessor_trap;
            s0_rd_q   <= accessor_rd;
            s0_data_q <= accessor_rd_data;
          end
        end
      end else if (accept) begin
        if (!s0_valid_q) begin
          s0_valid_q <= 1'b1;
          s0_trap_q  <= accessor_trap;
          s0_rd_q    <= accessor_rd;
          s0_data_q  <= accessor_rd_data;
        end else begin
          s1_valid_q <= 1'b1;
          s1_trap_q  <= accessor_trap;
          s1_rd_q    <= accessor_rd;
          s1_data_q  <= accessor_rd_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_retire_writeback.sv
module tb_retire_writeback;

  typedef struct {
    logic        rst;
    logic        v;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        tr;
    logic        wr;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
  } in_t;

  typedef struct {
    logic        rdy;
    logic        wen;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        rv;
    logic [63:0] ord;
    logic        h1;
    logic [31:0] d1;
    logic        h2;
    logic [31:0] d2;
    logic        trap;
  } out_t;

  typedef struct {
    in_t  i;
    out_t e;
  } vec_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  // ---------------- main DUT ----------------
  logic        accessor_valid = 1'b0, writeback_ready;
  logic [4:0]  accessor_rd = '0;
  logic [31:0] accessor_rd_data = '0;
  logic        accessor_trap = 1'b0, wport_ready = 1'b0;
  logic        wen;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [4:0]  fwd_rs1 = '0, fwd_rs2 = '0;
  logic        fwd_hit1, fwd_hit2;
  logic [31:0] fwd_data1, fwd_data2;
  logic        retire_valid;
  logic [63:0] retire_order;
  logic        trap;
  logic [0:0]  fsm_state;

  retire_writeback #(.ORDER_W(64)) dut (
    .clk(clk), .reset(reset),
    .accessor_valid(accessor_valid), .writeback_ready(writeback_ready),
    .accessor_rd(accessor_rd), .accessor_rd_data(accessor_rd_data),
    .accessor_trap(accessor_trap), .wport_ready(wport_ready),
    .wen(wen), .waddr(waddr), .wdata(wdata),
    .fwd_rs1(fwd_rs1), .fwd_rs2(fwd_rs2),
    .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2),
    .fwd_data1(fwd_data1), .fwd_data2(fwd_data2),
    .retire_valid(retire_valid), .retire_order(retire_order),
    .trap(trap), .fsm_state(fsm_state)
  );

  // ---------------- narrow-counter DUT for the wrap case ----------------
  logic        w_valid = 1'b0, w_wr = 1'b0, w_ready;
  logic [4:0]  w_rd = 5'd1, w_rs = 5'd0;
  logic [31:0] w_data = 32'h1234;
  logic        w_tr = 1'b0;
  logic        w_wen, w_h1, w_h2, w_rv, w_trap;
  logic [4:0]  w_waddr;
  logic [31:0] w_wdata, w_d1, w_d2;
  logic [3:0]  w_order;
  logic [0:0]  w_fsm;

  retire_writeback #(.ORDER_W(4)) dut_w (
    .clk(clk), .reset(reset),
    .accessor_valid(w_valid), .writeback_ready(w_ready),
    .accessor_rd(w_rd), .accessor_rd_data(w_data),
    .accessor_trap(w_tr), .wport_ready(w_wr),
    .wen(w_wen), .waddr(w_waddr), .wdata(w_wdata),
    .fwd_rs1(w_rs), .fwd_rs2(w_rs),
    .fwd_hit1(w_h1), .fwd_hit2(w_h2),
    .fwd_data1(w_d1), .fwd_data2(w_d2),
    .retire_valid(w_rv), .retire_order(w_order),
    .trap(w_trap), .fsm_state(w_fsm)
  );

  // ---------------- scoreboard / reference model ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [37:0] exp_q[$];   // pending results, oldest first: {trap, rd, data}
  logic        m_alive;
  logic        m_trapped;
  logic [63:0] m_order;
  vec_t        vecs[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_out(input string tag, input out_t e);
    chk({tag, ".ready"}, 64'(writeback_ready), 64'(e.rdy));
    chk({tag, ".wen"},   64'(wen),             64'(e.wen));
    chk({tag, ".waddr"}, 64'(waddr),           64'(e.waddr));
    chk({tag, ".wdata"}, 64'(wdata),           64'(e.wdata));
    chk({tag, ".rv"},    64'(retire_valid),    64'(e.rv));
    chk({tag, ".order"}, retire_order,         e.ord);
    chk({tag, ".hit1"},  64'(fwd_hit1),        64'(e.h1));
    chk({tag, ".data1"}, 64'(fwd_data1),       64'(e.d1));
    chk({tag, ".hit2"},  64'(fwd_hit2),        64'(e.h2));
    chk({tag, ".data2"}, 64'(fwd_data2),       64'(e.d2));
    chk({tag, ".trap"},  64'(trap),            64'(e.trap));
  endtask

  // ---------------- driver ----------------
  task automatic drive(input in_t i);
    reset            = i.rst;
    accessor_valid   = i.v;
    accessor_rd      = i.rd;
    accessor_rd_data = i.data;
    accessor_trap    = i.tr;
    wport_ready      = i.wr;
    fwd_rs1          = i.rs1;
    fwd_rs2          = i.rs2;
  endtask

  function automatic void add(input logic rst, input logic v, input logic [4:0] rd,
                              input logic [31:0] data, input logic tr, input logic wr,
                              input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic rdy, input logic we, input logic [4:0] wa,
                              input logic [31:0] wd, input logic rv, input logic [63:0] ord,
                              input logic h1, input logic [31:0] d1, input logic h2,
                              input logic [31:0] d2, input logic tp);
    vec_t x;
    x.i = '{rst, v, rd, data, tr, wr, rs1, rs2};
    x.e = '{rdy, we, wa, wd, rv, ord, h1, d1, h2, d2, tp};
    vecs.push_back(x);
  endfunction

  function automatic void model_reset();
    exp_q.delete();
    m_alive   = 1'b0;
    m_trapped = 1'b0;
    m_order   = '0;
  endfunction

  // Forward lookup: scan from youngest to oldest pending result.
  function automatic logic [32:0] model_fwd(input logic [4:0] rs);
    if (rs == 5'd0) return 33'd0;
    for (int k = exp_q.size() - 1; k >= 0; k--)
      if (!exp_q[k][37] && exp_q[k][36:32] == rs) return {1'b1, exp_q[k][31:0]};
    return 33'd0;
  endfunction

  function automatic out_t model_predict(input in_t i);
    out_t o;
    int   sz;
    o  = '{default: '0};
    sz = exp_q.size();
    o.rdy  = i.rst & m_alive & !m_trapped & (sz < 2);
    o.rv   = i.rst & !m_trapped & (sz > 0) & i.wr;
    if (sz > 0) begin
      o.waddr = exp_q[0][36:32];
      o.wdata = exp_q[0][31:0];
      o.wen   = o.rv & !exp_q[0][37] & (exp_q[0][36:32] != 5'd0);
    end
    o.ord  = m_order;
    o.trap = m_trapped;
    {o.h1, o.d1} = model_fwd(i.rs1);
    {o.h2, o.d2} = model_fwd(i.rs2);
    return o;
  endfunction

  function automatic void model_step(input in_t i, input out_t p);
    logic [37:0] head;
    if (!i.rst) return;
    if (p.rv) begin
      head = exp_q.pop_front();
      m_order++;
      if (head[37]) begin
        m_trapped = 1'b1;
        exp_q.delete();
      end
    end
    if (i.v && p.rdy && !m_trapped) exp_q.push_back({i.tr, i.rd, i.data});
    m_alive = 1'b1;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    in_t  ri;
    out_t p;

    // reset with beats offered, release, ready one cycle later
    add(0,1,1,'h77,0,1,0,0, 0,0,0,0,0,0, 0,0,0,0,0);
    add(0,1,2,'h78,0,1,1,2, 0,0,0,0,0,0, 0,0,0,0,0);
    add(1,1,3,'h79,0,1,0,0, 0,0,0,0,0,0, 0,0,0,0,0);
    // streaming rd 1..5
    add(1,1,1,'h10,0,1,0,0, 1,0,0,0,0,0, 0,0,0,0,0);
    add(1,1,2,'h20,0,1,1,0, 1,1,1,'h10,1,0, 1,'h10,0,0,0);
    add(1,1,3,'h30,0,1,0,0, 1,1,2,'h20,1,1, 0,0,0,0,0);
    add(1,1,4,'h40,0,1,0,0, 1,1,3,'h30,1,2, 0,0,0,0,0);
    add(1,1,5,'h50,0,1,0,0, 1,1,4,'h40,1,3, 0,0,0,0,0);
    add(1,0,0,0,0,1,0,0,    1,1,5,'h50,1,4, 0,0,0,0,0);
    add(1,0,0,0,0,1,0,0,    1,0,0,0,0,5,    0,0,0,0,0);
    // backpressure: 3rd beat held until a slot frees
    add(1,1,3,'hA,0,0,0,0,  1,0,0,0,0,5,    0,0,0,0,0);
    add(1,1,4,'hB,0,0,0,0,  1,0,3,'hA,0,5,  0,0,0,0,0);
    add(1,1,5,'hC,0,0,0,0,  0,0,3,'hA,0,5,  0,0,0,0,0);
    add(1,1,5,'hC,0,1,0,0,  0,1,3,'hA,1,5,  0,0,0,0,0);
    add(1,1,5,'hC,0,1,0,0,  1,1,4,'hB,1,6,  0,0,0,0,0);
    add(1,0,0,0,0,1,0,0,    1,1,5,'hC,1,7,  0,0,0,0,0);
    // bypass: S1 (younger) wins over S0
    add(1,1,7,'h1,0,0,7,0,  1,0,0,0,0,8,    0,0,0,0,0);
    add(1,1,7,'h2,0,0,7,0,  1,0,7,'h1,0,8,  1,'h1,0,0,0);
    add(1,0,0,0,0,0,7,0,    0,0,7,'h1,0,8,  1,'h2,0,0,0);
    add(1,0,0,0,0,1,7,0,    0,1,7,'h1,1,8,  1,'h2,0,0,0);
    add(1,0,0,0,0,1,7,0,    1,1,7,'h2,1,9,  1,'h2,0,0,0);
    add(1,0,0,0,0,1,7,0,    1,0,0,0,0,10,   0,0,0,0,0);
    // x0 retires without a write; trap beat then rd=2
    add(1,1,0,'hFF,0,1,0,0, 1,0,0,0,0,10,   0,0,0,0,0);
    add(1,1,9,'h99,1,1,9,0, 1,0,0,'hFF,1,10, 0,0,0,0,0);
    add(1,1,2,'h22,0,0,9,2, 1,0,9,'h99,0,11, 0,0,0,0,0);
    add(1,0,0,0,0,0,9,2,    0,0,9,'h99,0,11, 0,0,1,'h22,0);
    add(1,0,0,0,0,1,9,2,    0,0,9,'h99,1,11, 0,0,1,'h22,0);
    add(1,1,6,'h66,0,1,0,2, 0,0,0,0,0,12,   0,0,0,0,1);
    add(1,1,6,'h66,0,1,0,2, 0,0,0,0,0,12,   0,0,0,0,1);
    // reset leaves TRAPPED
    add(0,1,1,'h5,0,1,0,0,  0,0,0,0,0,0,    0,0,0,0,0);
    add(1,1,1,'h5,0,1,0,0,  0,0,0,0,0,0,    0,0,0,0,0);
    add(1,1,1,'h5,0,1,0,0,  1,0,0,0,0,0,    0,0,0,0,0);
    add(1,0,0,0,0,1,0,0,    1,1,1,'h5,1,0,  0,0,0,0,0);
    // reset while the head is stalled: no write afterwards
    add(1,1,8,'h88,0,0,0,0, 1,0,0,0,0,1,    0,0,0,0,0);
    add(1,0,0,0,0,0,8,0,    1,0,8,'h88,0,1, 1,'h88,0,0,0);
    add(0,0,0,0,0,1,8,0,    0,0,0,0,0,0,    0,0,0,0,0);
    add(1,0,0,0,0,1,8,0,    0,0,0,0,0,0,    0,0,0,0,0);
    add(1,0,0,0,0,1,8,0,    1,0,0,0,0,0,    0,0,0,0,0);

    for (int n = 0; n < vecs.size(); n++) begin
      @(negedge clk);
      drive(vecs[n].i);
      #1;
      check_out($sformatf("vec%0d", n), vecs[n].e);
      @(posedge clk);
    end

    // randomized run against the queue model; first cycle is a reset
    model_reset();
    for (int n = 0; n < 1500; n++) begin
      ri.rst  = (n == 0) ? 1'b0 : ($urandom_range(0, 39) != 0);
      ri.v    = ($urandom_range(0, 9) < 7);
      ri.rd   = 5'($urandom_range(0, 7));
      ri.data = $urandom;
      ri.tr   = ($urandom_range(0, 29) == 0);
      ri.wr   = ($urandom_range(0, 9) < 6);
      ri.rs1  = 5'($urandom_range(0, 7));
      ri.rs2  = 5'($urandom_range(0, 7));
      @(negedge clk);
      drive(ri);
      if (!ri.rst) model_reset();
      #1;
      p = model_predict(ri);
      check_out($sformatf("rnd%0d", n), p);
      @(posedge clk);
      model_step(ri, p);
    end

    // retire_order wrap on a 4-bit counter: ... 14, 15 (all ones), 0
    @(negedge clk);
    accessor_valid = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k <= 17; k++) begin
      @(negedge clk);
      w_valid = (k < 17);
      w_wr    = 1'b1;
      #1;
      chk($sformatf("wrap%0d.rv", k), 64'(w_rv), 64'(k > 0));
      if (k > 0)
        chk($sformatf("wrap%0d.order", k), 64'(w_order), 64'((k - 1) % 16));
    end
    w_valid = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
